// File: rtl/bin_to_dec.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock, start/done handshake.
// Define BIN_TO_DEC_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin_to_dec #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     acc_shift;
    logic [WIDTH-1:0]  sh_shift;
    logic              carry;
    logic [WIDTH-1:0]  mag;
    logic              sign_in;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                               : acc_q[4*gi +: 4];
        end
    endgenerate

    // The bit leaving the top nibble is worth 10**DIGITS; it only feeds the overflow flag.
    assign carry     = adj[BW-1];
    assign acc_shift = {adj[BW-2:0], sh_q[WIDTH-1]};
    assign sh_shift  = {sh_q[WIDTH-2:0], 1'b0};

`ifdef BIN_TO_DEC_SIGNED_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;
    assign sign_in = bin[WIDTH-1];
    assign mag     = sign_in ? (~bin + WIDTH'(1)) : bin;
    assign neg     = neg_q;
`else
    assign sign_in = 1'b0;
    assign mag     = bin;
    assign neg     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
`ifdef BIN_TO_DEC_SIGNED_EN
        sign_d   = sign_q;
        neg_d    = neg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d    = '0;
                    sh_d     = mag;
                    cnt_d    = CW'(WIDTH);
                    sticky_d = 1'b0;
`ifdef BIN_TO_DEC_SIGNED_EN
                    sign_d   = sign_in;
`endif
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                acc_d    = acc_shift;
                sh_d     = sh_shift;
                sticky_d = sticky_q | carry;
                cnt_d    = cnt_q - CW'(1);
                // Results are published on the final shift so they are valid during the done cycle.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    bcd_d   = acc_shift;
                    ovf_d   = sticky_q | carry;
`ifdef BIN_TO_DEC_SIGNED_EN
                    neg_d   = sign_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef BIN_TO_DEC_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            neg_q  <= neg_d;
        end
    end
`endif

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule
